// File: rtl/llmint8_outlier_scheduler.sv
// Tile buffer and column-wise outlier classifier feeding the int8/fp16 split.
// A tile of ROWS beats is captured while the outlier mask is built, then replayed with that mask.
module llmint8_outlier_scheduler #(
    parameter int IN_WIDTH      = 16,
    parameter int IN_FRAC_WIDTH = 0,
    parameter int THRES         = 127,
    parameter int IN_SIZE       = 4,
    parameter int ROWS          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_out,
    output logic [IN_SIZE-1:0]                outlier_mask,
    output logic                              data_out_last,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic                              dbg_state_o
);

    // Handshakes: a beat moves on a port only in a cycle where its valid and ready are both high;
    // valid never depends on ready, and an offered output beat is held until it is taken.

    localparam int IN_INT_WIDTH = IN_WIDTH - IN_FRAC_WIDTH;
    localparam int CNT_W        = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    if (IN_WIDTH - IN_FRAC_WIDTH <= 1) begin : g_chk_width
        $fatal(1, "IN_WIDTH-IN_FRAC_WIDTH must exceed 1");
    end
    if (THRES <= 0) begin : g_chk_thres
        $fatal(1, "THRES must be positive");
    end
    if (ROWS < 2) begin : g_chk_rows
        $fatal(1, "ROWS must be at least 2");
    end
    if (IN_SIZE < 1) begin : g_chk_size
        $fatal(1, "IN_SIZE must be at least 1");
    end

    typedef enum logic {
        SCAN = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]                    rd_cnt_q, rd_cnt_d;
    logic [IN_SIZE-1:0]                  mask_q, mask_d;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0]    tile_q [ROWS];
    logic [IN_SIZE-1:0]                  outlier_vec;
    logic                                accept;

    // Magnitude is one bit wider than the integer part so the most negative value cannot wrap.
    for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
        logic [IN_INT_WIDTH:0] int_ext;
        logic [IN_INT_WIDTH:0] mag;
        always_comb begin
            int_ext = {data_in[i][IN_WIDTH-1], data_in[i][IN_WIDTH-1:IN_FRAC_WIDTH]};
            mag     = int_ext[IN_INT_WIDTH] ? (~int_ext + 1'b1) : int_ext;
        end
        assign outlier_vec[i] = (64'(mag) > 64'(THRES));
    end

    assign accept      = data_in_valid && (state_q == SCAN);
    assign dbg_state_o = (state_q == EMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SCAN;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mask_q   <= mask_d;
        end
    end

    // Buffer contents are meaningless until a full tile has been written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tile_q[wr_cnt_q] <= data_in;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        mask_d         = mask_q;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out       = '0;
        outlier_mask   = '0;
        data_out_last  = 1'b0;
        case (state_q)
            SCAN: begin
                data_in_ready = 1'b1;
                if (data_in_valid) begin
                    mask_d = mask_q | outlier_vec;
                    if (wr_cnt_q == LAST_ROW) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = EMIT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                data_out_valid = 1'b1;
                data_out       = tile_q[rd_cnt_q];
                outlier_mask   = mask_q;
                data_out_last  = (rd_cnt_q == LAST_ROW);
                if (data_out_ready) begin
                    if (rd_cnt_q == LAST_ROW) begin
                        rd_cnt_d = '0;
                        mask_d   = '0;
                        state_d  = SCAN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

endmodule

// File: tb/tb_llmint8_outlier_scheduler.sv
// Bench for llmint8_outlier_scheduler: directed tiles, resets and random traffic against a tile-level model.
module tb_llmint8_outlier_scheduler;

    localparam int IN_WIDTH = 16;
    localparam int IN_SIZE  = 4;
    localparam int ROWS     = 4;
    localparam int THRES    = 127;
    localparam int EXP_W    = IN_SIZE*IN_WIDTH + IN_SIZE + 1;

    typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    beat_t              data_in = '0;
    logic               data_in_valid = 1'b0;
    logic               data_in_ready;
    beat_t              data_out;
    logic [IN_SIZE-1:0] outlier_mask;
    logic               data_out_last;
    logic               data_out_valid;
    logic               data_out_ready = 1'b1;
    logic               dbg_state;

    beat_t              f_data_in = '0;
    logic               f_in_valid = 1'b0;
    logic               f_in_ready;
    beat_t              f_data_out;
    logic [IN_SIZE-1:0] f_mask;
    logic               f_last;
    logic               f_out_valid;
    logic               f_out_ready = 1'b1;
    logic               f_dbg_state;

    int                 rdy_mode = 0;
    logic               lit_en = 1'b0;
    logic [IN_SIZE-1:0] lit_mask = '0;
    logic               end_req = 1'b0;
    beat_t              drv_tile [ROWS];

    int                 pass_cnt = 0;
    int                 chk_cnt = 0;
    logic [EXP_W-1:0]   exp_q [$];
    beat_t              mdl_tile [ROWS];
    int                 mdl_rows = 0;
    int                 f_beats = 0;
    logic               end_done = 1'b0;

    llmint8_outlier_scheduler #(
        .IN_WIDTH(IN_WIDTH), .IN_FRAC_WIDTH(0), .THRES(THRES), .IN_SIZE(IN_SIZE), .ROWS(ROWS)
    ) u_dut (
        .clk(clk), .rst(rst_n),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .outlier_mask(outlier_mask), .data_out_last(data_out_last),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .dbg_state_o(dbg_state)
    );

    llmint8_outlier_scheduler #(
        .IN_WIDTH(IN_WIDTH), .IN_FRAC_WIDTH(8), .THRES(THRES), .IN_SIZE(IN_SIZE), .ROWS(ROWS)
    ) u_dut_frac (
        .clk(clk), .rst(rst_n),
        .data_in(f_data_in), .data_in_valid(f_in_valid), .data_in_ready(f_in_ready),
        .data_out(f_data_out), .outlier_mask(f_mask), .data_out_last(f_last),
        .data_out_valid(f_out_valid), .data_out_ready(f_out_ready),
        .dbg_state_o(f_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       data_out_ready = ($urandom_range(0, 3) != 0);
            2:       data_out_ready = 1'b0;
            default: data_out_ready = 1'b1;
        endcase
    end

    // ---------------- model ----------------
    function automatic bit is_outlier(input logic [IN_WIDTH-1:0] e, input int frac);
        int v;
        v = int'($signed(e)) >>> frac;
        if (v < 0) v = -v;
        return v > THRES;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 128'(data_in_ready), 128'(1));
            chk("rst_out_valid", 128'(data_out_valid), 128'(0));
            chk("rst_out_last", 128'(data_out_last), 128'(0));
            chk("rst_mask", 128'(outlier_mask), 128'(0));
            exp_q.delete();
            mdl_rows = 0;
        end else begin
            if (exp_q.size() == 0) begin
                chk("scan_in_ready", 128'(data_in_ready), 128'(1));
                chk("scan_out_valid", 128'(data_out_valid), 128'(0));
                chk("scan_state", 128'(dbg_state), 128'(0));
                if (data_in_valid) begin
                    mdl_tile[mdl_rows] = data_in;
                    mdl_rows++;
                    if (mdl_rows == ROWS) begin
                        logic [IN_SIZE-1:0] m;
                        m = '0;
                        for (int r = 0; r < ROWS; r++)
                            for (int c = 0; c < IN_SIZE; c++)
                                if (is_outlier(mdl_tile[r][c], 0)) m[c] = 1'b1;
                        for (int r = 0; r < ROWS; r++)
                            exp_q.push_back({mdl_tile[r], m, (r == ROWS-1)});
                        mdl_rows = 0;
                    end
                end
            end else begin
                chk("emit_in_ready", 128'(data_in_ready), 128'(0));
                chk("emit_out_valid", 128'(data_out_valid), 128'(1));
                chk("emit_state", 128'(dbg_state), 128'(1));
                chk("out_beat", 128'({data_out, outlier_mask, data_out_last}), 128'(exp_q[0]));
                if (lit_en) chk("lit_mask", 128'(outlier_mask), 128'(lit_mask));
                if (data_out_ready) void'(exp_q.pop_front());
            end
            if (f_out_valid) begin
                chk("frac_mask", 128'(f_mask), 128'(4'b0010));
                f_beats++;
            end
            if (end_req && !end_done) begin
                chk("frac_beats", 128'(f_beats), 128'(ROWS));
                chk("end_drained", 128'(exp_q.size()), 128'(0));
                end_done = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input beat_t b);
        bit acc;
        data_in = b;
        data_in_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = data_in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n > 500) begin
                $display("FAIL send_beat: data_in_ready stayed %b", data_in_ready);
                $fatal(1, "timeout");
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic send_tile(input bit gaps);
        for (int r = 0; r < ROWS; r++) begin
            if (gaps) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) begin
                    data_in = beat_t'({$urandom, $urandom});
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(drv_tile[r]);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (data_in_ready && !data_out_valid) break;
            if (n > 500) begin
                $display("FAIL wait_idle: out_valid %b in_ready %b", data_out_valid, data_in_ready);
                $fatal(1, "timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tile();
        for (int r = 0; r < ROWS; r++) drv_tile[r] = '0;
    endtask

    task automatic directed(input logic [IN_SIZE-1:0] m);
        lit_mask = m;
        lit_en = 1'b1;
        send_tile(1'b0);
        wait_idle();
        lit_en = 1'b0;
    endtask

    function automatic logic [IN_WIDTH-1:0] rand_elem();
        int s;
        s = $urandom_range(0, 39);
        case (s)
            0:       return IN_WIDTH'($urandom);
            1:       return 16'd128;
            2:       return 16'hFF80;
            default: return IN_WIDTH'($urandom_range(0, 254)) - 16'd127;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fractional-format instance: int 127 is not an outlier, int -128 is
        f_in_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            f_data_in = '0;
            if (r == 0) begin
                f_data_in[0] = 16'h7F80;
                f_data_in[1] = 16'h8000;
            end
            @(posedge clk);
            #1;
        end
        f_in_valid = 1'b0;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < IN_SIZE; c++) drv_tile[r][c] = IN_WIDTH'(4*r + c + 1);
        directed(4'b0000);

        clear_tile();
        drv_tile[1][1] = 16'd128;
        drv_tile[3][3] = 16'hFF80;
        directed(4'b1010);

        clear_tile();
        drv_tile[1][1] = 16'd127;
        drv_tile[3][3] = 16'hFF81;
        directed(4'b0000);

        clear_tile();
        drv_tile[0][0] = 16'h8000;
        directed(4'b0001);

        // back-to-back tiles: stale mask bits would show up on the second
        clear_tile();
        drv_tile[0][2] = 16'd200;
        send_tile(1'b0);
        clear_tile();
        send_tile(1'b0);
        wait_idle();

        // reset after two beats of a tile that carries a column-0 outlier
        clear_tile();
        drv_tile[0][0] = 16'd1000;
        send_beat(drv_tile[0]);
        send_beat(drv_tile[1]);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset on the first replayed beat while downstream stalls
        rdy_mode = 2;
        clear_tile();
        drv_tile[2][1] = 16'd500;
        send_tile(1'b0);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (data_out_valid) break;
            if (n > 50) begin
                $display("FAIL emit_wait: data_out_valid stayed %b", data_out_valid);
                $fatal(1, "timeout");
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;

        clear_tile();
        drv_tile[3][3] = 16'd129;
        directed(4'b1000);

        rdy_mode = 1;
        for (int t = 0; t < 50; t++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < IN_SIZE; c++) drv_tile[r][c] = rand_elem();
            send_tile(1'b1);
        end
        wait_idle();
        rdy_mode = 0;

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
